// File: rtl/exe_alu_seq.sv
// exe_alu_seq: execute-stage ALU with a registered result, valid/ready
// handshake, an NZCV status register and an iterative shift-add MUL/MLA.
module exe_alu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       EXE_CMD,
   input  logic             S,
   input  logic [WIDTH-1:0] Val1,
   input  logic [WIDTH-1:0] Val2,
   input  logic [WIDTH-1:0] Val3,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       status
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MULT = 1'b1;

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;
   localparam logic [3:0] OP_MLA = 4'b1011;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [0:0]       state_q,     state_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic [3:0]       status_q,    status_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             s_q,         s_d;

   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_nzcv;
   logic             is_mul;
   logic [WIDTH-1:0] acc_step;

   // Reset also forces in_ready low so nothing is accepted on a reset edge.
   assign in_ready  = ~rst & (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign status    = status_q;

   assign is_mul   = (EXE_CMD == OP_MUL) || (EXE_CMD == OP_MLA);
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Single-cycle datapath: result and the flags it would write if S is set.
   always_comb begin
      alu_sum  = '0;
      alu_res  = '0;
      alu_nzcv = status_q;
      case (EXE_CMD)
         OP_MOV: alu_res = Val2;
         OP_MVN: alu_res = ~Val2;
         OP_AND: alu_res = Val1 & Val2;
         OP_ORR: alu_res = Val1 | Val2;
         OP_EOR: alu_res = Val1 ^ Val2;
         OP_ADD: alu_sum = {1'b0, Val1} + {1'b0, Val2};
         OP_ADC: alu_sum = {1'b0, Val1} + {1'b0, Val2} + {{WIDTH{1'b0}}, status_q[1]};
         // Subtract as Val1 + ~Val2 + cin so carry out means "no borrow".
         OP_SUB: alu_sum = {1'b0, Val1} + {1'b0, ~Val2} + {{WIDTH{1'b0}}, 1'b1};
         OP_SBC: alu_sum = {1'b0, Val1} + {1'b0, ~Val2} + {{WIDTH{1'b0}}, status_q[1]};
         default: alu_res = '0;
      endcase
      case (EXE_CMD)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res = alu_sum[WIDTH-1:0];
         default: ;
      endcase
      case (EXE_CMD)
         OP_MOV, OP_MVN, OP_AND, OP_ORR, OP_EOR: begin
            alu_nzcv[3] = alu_res[WIDTH-1];
            alu_nzcv[2] = (alu_res == '0);
         end
         OP_ADD, OP_ADC: begin
            alu_nzcv[3] = alu_res[WIDTH-1];
            alu_nzcv[2] = (alu_res == '0);
            alu_nzcv[1] = alu_sum[WIDTH];
            alu_nzcv[0] = (Val1[WIDTH-1] == Val2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != Val1[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            alu_nzcv[3] = alu_res[WIDTH-1];
            alu_nzcv[2] = (alu_res == '0);
            alu_nzcv[1] = alu_sum[WIDTH];
            alu_nzcv[0] = (Val1[WIDTH-1] != Val2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != Val1[WIDTH-1]);
         end
         default: ;
      endcase
   end

   // Control FSM: single-cycle ops retire at accept, MUL/MLA iterate one bit per cycle.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      status_d    = status_q;
      out_valid_d = 1'b0;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      count_d     = count_q;
      s_d         = s_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               if (is_mul) begin
                  mcand_d  = Val1;
                  mplier_d = Val2;
                  acc_d    = (EXE_CMD == OP_MLA) ? Val3 : '0;
                  s_d      = S;
                  count_d  = '0;
                  state_d  = ST_MULT;
               end else begin
                  result_d    = alu_res;
                  out_valid_d = 1'b1;
                  if (S) status_d = alu_nzcv;
               end
            end
         end
         default: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == LAST_CNT) begin
               result_d    = acc_step;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
               // Multiply only defines N and Z; C and V carry over.
               if (s_q) status_d = {acc_step[WIDTH-1], (acc_step == '0), status_q[1:0]};
            end
         end
      endcase
   end

   // State registers with synchronous reset; reset also aborts a multiply in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         status_q    <= 4'b0000;
         out_valid_q <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         s_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         s_q         <= s_d;
      end
   end

endmodule

// File: tb/tb_exe_alu_seq.sv
// tb_exe_alu_seq: directed bench for exe_alu_seq at WIDTH=32 and WIDTH=8.
module tb_exe_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        iv32 = 1'b0, ir32, ov32, s32 = 1'b0;
   logic [3:0]  cmd32 = 4'd0, st32;
   logic [31:0] a32 = '0, b32 = '0, c32 = '0, r32;

   logic        iv8 = 1'b0, ir8, ov8, s8 = 1'b0;
   logic [3:0]  cmd8 = 4'd0, st8;
   logic [7:0]  a8 = '0, b8 = '0, c8 = '0, r8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exe_alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .EXE_CMD(cmd32), .S(s32),
      .Val1(a32), .Val2(b32), .Val3(c32), .out_valid(ov32), .result(r32), .status(st32)
   );

   exe_alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .EXE_CMD(cmd8), .S(s8),
      .Val1(a8), .Val2(b8), .Val3(c8), .out_valid(ov8), .result(r8), .status(st8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv32(input logic [3:0] c, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] z);
      iv32 = 1'b1; cmd32 = c; s32 = s; a32 = x; b32 = y; c32 = z;
   endtask

   task automatic drv8(input logic [3:0] c, input logic s, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] z);
      iv8 = 1'b1; cmd8 = c; s8 = s; a8 = x; b8 = y; c8 = z;
   endtask

   logic seen;

   initial begin
      // Reset
      step(); step();
      chk("rst_ready", {31'd0, ir32}, 32'd0);
      chk("rst_result", r32, 32'd0);
      chk("rst_status", {28'd0, st32}, 32'd0);
      chk("rst_ovalid", {31'd0, ov32}, 32'd0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", {31'd0, ir32}, 32'd1);

      // ADDS overflow into sign bit
      drv32(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0);
      step(); iv32 = 1'b0;
      chk("adds_ov", {31'd0, ov32}, 32'd1);
      chk("adds_res", r32, 32'h8000_0000);
      chk("adds_st", {28'd0, st32}, 32'h9);
      step();
      chk("adds_ov_drop", {31'd0, ov32}, 32'd0);
      chk("adds_res_hold", r32, 32'h8000_0000);

      // SUBS 5-5 then SBC (S=0) 3-1 back-to-back
      drv32(4'b0100, 1'b1, 32'd5, 32'd5, 32'd0);
      step();
      chk("subs_res", r32, 32'd0);
      chk("subs_st", {28'd0, st32}, 32'h6);
      drv32(4'b0101, 1'b0, 32'd3, 32'd1, 32'd0);
      step(); iv32 = 1'b0;
      chk("sbc_ov", {31'd0, ov32}, 32'd1);
      chk("sbc_res", r32, 32'd2);
      chk("sbc_st", {28'd0, st32}, 32'h6);
      step();

      // ADDS carry-out then ADCS 0+0 consumes it
      drv32(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0);
      step();
      chk("adds_c_res", r32, 32'd0);
      chk("adds_c_st", {28'd0, st32}, 32'h6);
      drv32(4'b0011, 1'b1, 32'd0, 32'd0, 32'd0);
      step(); iv32 = 1'b0;
      chk("adcs_res", r32, 32'd1);
      chk("adcs_st", {28'd0, st32}, 32'h0);
      step();

      // Set C=1 so the multiply can be seen to preserve it
      drv32(4'b0100, 1'b1, 32'd5, 32'd5, 32'd0);
      step(); iv32 = 1'b0;
      chk("pre_mul_st", {28'd0, st32}, 32'h6);
      step();

      // MULS 0x00010001 * 0x00010001, latency 32
      drv32(4'b1010, 1'b1, 32'h0001_0001, 32'h0001_0001, 32'd0);
      step(); iv32 = 1'b0;
      chk("mul_busy0", {30'd0, ir32, ov32}, 32'd0);
      seen = 1'b0;
      for (int i = 1; i < 32; i++) begin
         step();
         if (ir32 !== 1'b0 || ov32 !== 1'b0) seen = 1'b1;
      end
      chk("mul_busy_window", {31'd0, seen}, 32'd0);
      step();
      chk("mul_ov", {31'd0, ov32}, 32'd1);
      chk("mul_ready", {31'd0, ir32}, 32'd1);
      chk("mul_res", r32, 32'h0002_0001);
      chk("mul_st", {28'd0, st32}, 32'h2);
      step();
      chk("mul_ov_drop", {31'd0, ov32}, 32'd0);

      // MLA at WIDTH=8: 0x0F*0x11+1 wraps to 0, S=0 then S=1
      drv8(4'b1011, 1'b0, 8'h0F, 8'h11, 8'h01);
      step(); iv8 = 1'b0;
      seen = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step();
         if (ov8 !== 1'b0) seen = 1'b1;
      end
      chk("mla8_early", {31'd0, seen}, 32'd0);
      step();
      chk("mla8_ov", {31'd0, ov8}, 32'd1);
      chk("mla8_res", {24'd0, r8}, 32'd0);
      chk("mla8_st_s0", {28'd0, st8}, 32'h0);
      step();
      drv8(4'b1011, 1'b1, 8'h0F, 8'h11, 8'h01);
      step(); iv8 = 1'b0;
      repeat (7) step();
      step();
      chk("mla8s_ov", {31'd0, ov8}, 32'd1);
      chk("mla8s_res", {24'd0, r8}, 32'd0);
      chk("mla8s_st", {28'd0, st8}, 32'h4);
      step();

      // Reset in the middle of a multiply
      drv32(4'b1010, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'd0);
      step(); iv32 = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      chk("midrst_ov", {31'd0, ov32}, 32'd0);
      chk("midrst_st", {28'd0, st32}, 32'h0);
      chk("midrst_res", r32, 32'd0);
      chk("midrst_ready", {31'd0, ir32}, 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ov32 !== 1'b0) seen = 1'b1;
      end
      chk("aborted_no_ov", {31'd0, seen}, 32'd0);
      chk("after_abort_ready", {31'd0, ir32}, 32'd1);

      // NOP (1111) with S=1: result 0, pulses, status untouched
      drv32(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0);
      step();
      chk("pre_nop_st", {28'd0, st32}, 32'h9);
      drv32(4'b1111, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
      step(); iv32 = 1'b0;
      chk("nop_ov", {31'd0, ov32}, 32'd1);
      chk("nop_res", r32, 32'd0);
      chk("nop_st", {28'd0, st32}, 32'h9);
      step();
      chk("nop_ov_drop", {31'd0, ov32}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
